// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_rx_pkg;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_decoder_if.sv
// Byte stream and status bundle leaving the UART receiver.
interface uart_rx_decoder_if;
  import uart_rx_pkg::*;

  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 frame_err;
  logic                 overrun;
  logic [7:0]           overrun_cnt;

  modport master (
    output m_data, m_valid, frame_err, overrun, overrun_cnt,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, frame_err, overrun, overrun_cnt,
    output m_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a
// pop frees a slot in the same cycle. Head reads as zero while empty.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_push,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] L_FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == L_FULL_CNT);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver: input synchronizer, bit-timing state machine, shift
// register, output FIFO and saturating overrun counter.
module uart_rx_decoder
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_rx,
  uart_rx_decoder_if.master  m_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] L_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] L_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] L_LAST = IDX_W'(DATA_BITS - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  rx_state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   w_cnt_zero;
  logic                   w_bit_en;
  logic                   w_push;
  logic                   w_ovr_evt;
  logic                   w_ferr_evt;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic [7:0]             r_ovr_cnt;
  logic [DATA_BITS-1:0]   w_fifo_data;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  assign w_rx_s     = r_sync[SYNC_STAGES-1];
  assign w_cnt_zero = (r_cnt == '0);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
  end

  // Receiver state, bit-timing counter and data bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic; a full FIFO only overruns if the consumer is not
  // popping in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_bit_en    = 1'b0;
    w_push      = 1'b0;
    w_ovr_evt   = 1'b0;
    w_ferr_evt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_cnt_nxt   = L_HALF;
          w_state_nxt = START;
        end
      end
      START: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (!w_rx_s) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
          w_cnt_nxt   = L_BIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_bit_en  = 1'b1;
          w_cnt_nxt = L_BIT;
          if (r_idx == L_LAST) w_state_nxt = STOP;
          else                 w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_rx_s) begin
          if (w_fifo_full && !m_if.m_ready) w_ovr_evt = 1'b1;
          else                              w_push    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_ferr_evt  = 1'b1;
          w_state_nxt = BREAK;
        end
      end
      BREAK: begin
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register: each sampled data bit lands at its own index, LSB first.
  always_ff @(posedge clk) begin
    if (w_bit_en) r_shift[r_idx] <= w_rx_s;
  end

  // Registered status pulses and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_ovr_cnt   <= '0;
    end else begin
      r_frame_err <= w_ferr_evt;
      r_overrun   <= w_ovr_evt;
      if (w_ovr_evt) r_ovr_cnt <= sat_inc(r_ovr_cnt);
    end
  end

  uart_rx_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (r_shift),
    .i_push  (w_push),
    .i_pop   (m_if.m_ready),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign m_if.m_data      = w_fifo_data;
  assign m_if.m_valid     = !w_fifo_empty;
  assign m_if.frame_err   = r_frame_err;
  assign m_if.overrun     = r_overrun;
  assign m_if.overrun_cnt = r_ovr_cnt;

endmodule
